// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if
//   Handshake and data bundle for the execute stage.
//   Upstream (decode -> execute):
//     in_valid/in_ready handshake, in_a/in_b/in_imm operands, in_alusrc,
//     in_aluop, in_funct, in_branch, in_rd.
//   Downstream (execute -> writeback/branch):
//     out_valid/out_ready handshake, out_z, out_zero, out_taken,
//     out_illegal, out_rd.
//   master: the surrounding pipeline (drives in_* and out_ready).
//   slave : the execute stage itself.
interface alu_exec_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] in_imm;
   logic             in_alusrc;
   logic [1:0]       in_aluop;
   logic [5:0]       in_funct;
   logic             in_branch;
   logic [4:0]       in_rd;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_z;
   logic             out_zero;
   logic             out_taken;
   logic             out_illegal;
   logic [4:0]       out_rd;

   modport master (
      output in_valid, in_a, in_b, in_imm, in_alusrc, in_aluop, in_funct,
             in_branch, in_rd, out_ready,
      input  in_ready, out_valid, out_z, out_zero, out_taken, out_illegal,
             out_rd
   );

   modport slave (
      input  in_valid, in_a, in_b, in_imm, in_alusrc, in_aluop, in_funct,
             in_branch, in_rd, out_ready,
      output in_ready, out_valid, out_z, out_zero, out_taken, out_illegal,
             out_rd
   );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage: decodes the ALU op from aluop/funct, drives the
//   combinational ALU (yAlu) and captures results into a 2-entry output
//   queue toward writeback/branch resolution.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-high reset
//     bus   - alu_exec_stage_if.slave (upstream and downstream handshakes)

// yAlu
//   Combinational 32-bit ALU. Ops: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed).
//   Ports: i_a, i_b operands; i_op 3-bit op; o_z result.
module yAlu #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_z
);
   always_comb begin
      o_z = '0;
      case (i_op)
         3'd0:    o_z = i_a & i_b;
         3'd1:    o_z = i_a | i_b;
         3'd2:    o_z = i_a + i_b;
         3'd6:    o_z = i_a - i_b;
         3'd7:    o_z = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default: o_z = '0;
      endcase
   end
endmodule

module alu_exec_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           reset,
   alu_exec_stage_if.slave bus
);
   typedef enum logic [2:0] {
      OP_AND = 3'd0,
      OP_OR  = 3'd1,
      OP_ADD = 3'd2,
      OP_SUB = 3'd6,
      OP_SLT = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic [WIDTH-1:0] z;
      logic             zero;
      logic             taken;
      logic             illegal;
      logic [4:0]       rd;
   } entry_t;

   alu_op_e          w_op;
   logic             w_illegal;
   logic [WIDTH-1:0] w_alu_b;
   logic [WIDTH-1:0] w_alu_z;
   entry_t           w_new;
   entry_t           w_head;
   logic             w_push;
   logic             w_pop;

   entry_t           r_mem [DEPTH];
   entry_t           r_last;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;

   // ALU op decode
   always_comb begin
      w_op      = OP_ADD;
      w_illegal = 1'b0;
      case (bus.in_aluop)
         2'b00: w_op = OP_ADD;
         2'b01: w_op = OP_SUB;
         2'b10: begin
            case (bus.in_funct)
               6'h20:   w_op = OP_ADD;
               6'h22:   w_op = OP_SUB;
               6'h24:   w_op = OP_AND;
               6'h25:   w_op = OP_OR;
               6'h2A:   w_op = OP_SLT;
               default: w_illegal = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_alu_b = bus.in_alusrc ? bus.in_imm : bus.in_b;

   yAlu #(.WIDTH(WIDTH)) u_alu (
      .i_a  (bus.in_a),
      .i_b  (w_alu_b),
      .i_op (w_op),
      .o_z  (w_alu_z)
   );

   // Illegal ops discard the ALU result: z=0, zero=1, never taken.
   always_comb begin
      w_new         = '0;
      w_new.z       = w_illegal ? '0 : w_alu_z;
      w_new.zero    = (w_new.z == '0);
      w_new.taken   = bus.in_branch & w_new.zero & ~w_illegal;
      w_new.illegal = w_illegal;
      w_new.rd      = bus.in_rd;
   end

   assign bus.in_ready  = (r_count != 2'd2);
   assign bus.out_valid = (r_count != 2'd0);
   assign w_push        = bus.in_valid & bus.in_ready;
   assign w_pop         = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_last   <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         // Shadow of the visible head so outputs hold once the queue drains.
         if (r_count != 2'd0) r_last <= r_mem[r_rd_ptr];
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head          = (r_count != 2'd0) ? r_mem[r_rd_ptr] : r_last;
   assign bus.out_z       = w_head.z;
   assign bus.out_zero    = w_head.zero;
   assign bus.out_taken   = w_head.taken;
   assign bus.out_illegal = w_head.illegal;
   assign bus.out_rd      = w_head.rd;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//   Directed bench for alu_exec_stage with hand-computed expected values.
module tb_alu_exec_stage;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_exec_stage_if #(.WIDTH(32)) bus ();

   alu_exec_stage #(.WIDTH(32), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // flags are {zero, taken, illegal}
   task automatic chk_out(input string tag, input logic [31:0] z, input logic [2:0] flags,
                          input logic [4:0] rd);
      chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, ".z"}, 64'(bus.out_z), 64'(z));
      chk({tag, ".flags"}, 64'({bus.out_zero, bus.out_taken, bus.out_illegal}), 64'(flags));
      chk({tag, ".rd"}, 64'(bus.out_rd), 64'(rd));
   endtask

   task automatic issue(input logic [1:0] aluop, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic alusrc, input logic branch, input logic [4:0] rd);
      bus.in_aluop  = aluop;
      bus.in_funct  = funct;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_imm    = imm;
      bus.in_alusrc = alusrc;
      bus.in_branch = branch;
      bus.in_rd     = rd;
      bus.in_valid  = 1'b1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_imm    = '0;
      bus.in_alusrc = 1'b0;
      bus.in_aluop  = 2'b00;
      bus.in_funct  = '0;
      bus.in_branch = 1'b0;
      bus.in_rd     = '0;
      bus.out_ready = 1'b1;
      step();
      step();
      reset = 1'b0;

      // Reset state
      chk("rst.valid", 64'(bus.out_valid), 64'd0);
      chk("rst.ready", 64'(bus.in_ready), 64'd1);
      chk("rst.outs", 64'({bus.out_z, bus.out_zero, bus.out_taken, bus.out_illegal, bus.out_rd}), 64'd0);

      // Back-to-back ops at full throughput
      issue(2'b10, 6'h20, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 5'd3);
      step();
      chk_out("add", 32'd12, 3'b000, 5'd3);
      chk("add.ready", 64'(bus.in_ready), 64'd1);

      issue(2'b01, 6'h00, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b1, 5'd4);
      step();
      chk_out("beq_eq", 32'd0, 3'b110, 5'd4);
      chk("beq_eq.ready", 64'(bus.in_ready), 64'd1);

      issue(2'b01, 6'h00, 32'h1234, 32'h1235, 32'd0, 1'b0, 1'b1, 5'd5);
      step();
      chk_out("beq_ne", 32'hFFFF_FFFF, 3'b000, 5'd5);

      issue(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd6);
      step();
      chk_out("slt_neg", 32'd1, 3'b000, 5'd6);

      issue(2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 5'd7);
      step();
      chk_out("slt_pos", 32'd0, 3'b100, 5'd7);

      issue(2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 1'b0, 5'd8);
      step();
      chk_out("and", 32'h00F0_00F0, 3'b000, 5'd8);

      issue(2'b10, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 1'b0, 5'd9);
      step();
      chk_out("or", 32'hFFF0_FFF0, 3'b000, 5'd9);

      issue(2'b10, 6'h22, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 5'd10);
      step();
      chk_out("sub_wrap", 32'hFFFF_FFFE, 3'b000, 5'd10);

      // Branch flag on a non-SUB op still follows zero
      issue(2'b00, 6'h00, 32'd5, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1, 5'd11);
      step();
      chk_out("add_branch", 32'd0, 3'b110, 5'd11);

      // Illegal ops
      issue(2'b10, 6'h27, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd12);
      step();
      chk_out("ill_funct", 32'd0, 3'b101, 5'd12);

      issue(2'b11, 6'h20, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 5'd13);
      step();
      chk_out("ill_aluop", 32'd0, 3'b101, 5'd13);

      // Drain: outputs hold the last head
      bus.in_valid = 1'b0;
      step();
      chk("drain.valid", 64'(bus.out_valid), 64'd0);
      chk("drain.hold", 64'({bus.out_z, bus.out_illegal, bus.out_rd}), 64'({32'd0, 1'b1, 5'd13}));

      // Backpressure
      bus.out_ready = 1'b0;
      issue(2'b00, 6'h00, 32'd10, 32'h55, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd1);
      step();
      chk_out("bp1", 32'd8, 3'b000, 5'd1);
      chk("bp1.ready", 64'(bus.in_ready), 64'd1);

      issue(2'b00, 6'h00, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 5'd2);
      step();
      chk_out("bp2", 32'd8, 3'b000, 5'd1);
      chk("bp2.ready", 64'(bus.in_ready), 64'd0);

      issue(2'b00, 6'h00, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 5'd3);
      step();
      chk_out("bp3_held", 32'd8, 3'b000, 5'd1);
      chk("bp3_held.ready", 64'(bus.in_ready), 64'd0);
      step();
      chk_out("bp3_held2", 32'd8, 3'b000, 5'd1);

      bus.out_ready = 1'b1;
      step();
      chk_out("pop1", 32'd2, 3'b000, 5'd2);
      chk("pop1.ready", 64'(bus.in_ready), 64'd1);
      step();
      chk_out("pop2", 32'd6, 3'b000, 5'd3);
      bus.in_valid = 1'b0;
      step();
      chk("pop3.valid", 64'(bus.out_valid), 64'd0);
      chk("pop3.hold", 64'(bus.out_z), 64'd6);

      // Reset with a full queue and an op presented
      bus.out_ready = 1'b0;
      issue(2'b00, 6'h00, 32'd100, 32'd1, 32'd0, 1'b0, 1'b0, 5'd20);
      step();
      issue(2'b00, 6'h00, 32'd200, 32'd2, 32'd0, 1'b0, 1'b0, 5'd21);
      step();
      chk("full.ready", 64'(bus.in_ready), 64'd0);
      reset = 1'b1;
      issue(2'b00, 6'h00, 32'd300, 32'd3, 32'd0, 1'b0, 1'b0, 5'd22);
      step();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      chk("mrst.valid", 64'(bus.out_valid), 64'd0);
      chk("mrst.ready", 64'(bus.in_ready), 64'd1);
      chk("mrst.outs", 64'({bus.out_z, bus.out_zero, bus.out_taken, bus.out_illegal, bus.out_rd}), 64'd0);
      bus.out_ready = 1'b1;
      step();
      step();
      step();
      chk("mrst.after.valid", 64'(bus.out_valid), 64'd0);
      chk("mrst.after.z", 64'(bus.out_z), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage of the single-issue datapath. Accepts decoded operands and control from the decode stage over a valid/ready handshake.
- Generates the 3-bit ALU op from ALU-op class and funct, then drives the existing 32-bit ALU (yAlu).
- Buffers results in a 2-entry output queue toward writeback/branch resolution, with zero flag, branch-taken and illegal-funct indications.

Parameters:
- WIDTH, 32, operand/result width (must match ALU).
- DEPTH, 2, output queue entries (fixed at 2; only 2 is supported).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents an op.
- in_ready  output  1  stage can accept this cycle.
- in_a  input  32  rs operand.
- in_b  input  32  rt operand.
- in_imm  input  32  sign-extended immediate.
- in_alusrc  input  1  1: ALU B = in_imm, 0: ALU B = in_b.
- in_aluop  input  2  00 add (lw/sw), 01 sub (beq), 10 R-type use funct, 11 reserved.
- in_funct  input  6  R-type funct.
- in_branch  input  1  op is beq.
- in_rd  input  5  destination tag, passed through.
- out_valid  output  1  queue head valid.
- out_ready  input  1  downstream consumes head.
- out_z  output  32  ALU result.
- out_zero  output  1  out_z == 0.
- out_taken  output  1  in_branch & zero.
- out_illegal  output  1  unsupported aluop/funct.
- out_rd  output  5  tag.

Behaviour:
- ALU op encoding (3 bits): 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed; result 1 or 0).
- aluop 00 -> op 2; aluop 01 -> op 6.
- aluop 10 with funct 0x20 -> 2, 0x22 -> 6, 0x24 -> 0, 0x25 -> 1, 0x2A -> 7.
- Any other funct, or aluop 11: illegal. Entry stores z=0, zero=1, taken=0, illegal=1. The ALU result is ignored.
- ADD/SUB wrap modulo 2^32; no overflow flag.
- Accept = in_valid & in_ready. The ALU is combinational on the inputs; the result is captured into the queue tail at the accepting edge.
- Latency: accepted at edge t -> out_valid=1 from edge t onward, i.e. visible in the cycle after acceptance. Throughput 1 op/cycle when out_ready stays high.
- Pop = out_valid & out_ready. Head fields are stable while out_valid=1 and out_ready=0.
- Queue: count 0..2 with read/write pointers that wrap mod 2.
- in_ready = (count != 2), derived from registered count only. There is no combinational path from out_ready to in_ready.
- count=0: out_valid=0 and outputs hold the last values. Only the handshake bits are meaningful.
- count=1, push & pop same edge: count stays 1 and the new entry becomes head.
- count=2: no push is possible; a pop leaves count=1 and in_ready=1 next cycle.
- Pop at count=0 is ignored (out_valid=0 anyway).
- reset (sync, on edge with reset=1), regardless of in-flight state:
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - out_z=0, out_zero=0, out_taken=0, out_illegal=0, out_rd=0.
  - Buffered entries are discarded.
  - An in_valid in the reset cycle is not accepted.
- in_b is ignored when in_alusrc=1. in_branch with non-SUB op is legal; taken still = zero.

Test Plan:
- Reset, then R-type: aluop=10, funct=0x20, a=5, b=7, out_ready=1. Expect z=12, zero=0, taken=0 one cycle after accept; in_ready stays 1.
- Branch: aluop=01, branch=1, a=b=0x1234. Expect z=0, zero=1, taken=1. Repeat with b=0x1235: z=0xFFFFFFFF, taken=0.
- Signed SLT: funct=0x2A, a=0xFFFFFFFF (-1), b=1 -> z=1. Swap operands -> z=0. AND 0xF0F0F0F0&0x0FF00FF0=0x00F000F0; OR of the same = 0xFFF0FFF0.
- Backpressure: out_ready=0, push 3 ops (add with imm: alusrc=1, a=10, imm=0xFFFFFFFE -> 8; then 1+1=2; then 3+3).
  - Expect in_ready=0 after the 2nd accept and the 3rd held off.
  - Head stays z=8. After raising out_ready, results pop in order 8, 2, 6.
- Illegal: aluop=10, funct=0x27 -> z=0, zero=1, illegal=1, taken=0. aluop=11 likewise.
- Reset mid-operation: fill the queue to 2 and assert reset with in_valid=1. Next cycle: out_valid=0, in_ready=1, all outputs 0, and nothing is later delivered from the old entries.
